// File: rtl/hex_marquee.sv
`default_nettype none
// ============================================================================
// Module   : hex_marquee
// Purpose  : Scrolling-text driver for a bank of active-low 7-segment digits.
//            A runtime-loadable buffer of raw segment patterns is viewed
//            through a NUM_DIGITS-wide window that advances one character per
//            tick. A strobe marks every wrap from the last character to the
//            first.
// Ports    : clock    - system clock, all logic on posedge
//            resetn   - asynchronous active-low reset
//            run      - 1 = tick counter advances, 0 = scroll frozen
//            restart  - synchronous pulse: pos and tick counter cleared
//            wr_en    - write wr_data into buffer[wr_addr]
//            wr_addr  - buffer write address (AW bits)
//            wr_data  - raw active-low pattern {dp,g..a}, 8'hFF = blank
//            len_we   - load message length from len_data
//            len_data - new message length 0..MSG_DEPTH (larger is clamped)
//            bounce   - (HEX_MARQUEE_BOUNCE_EN only) ping-pong scrolling
//            seg_out  - digit k at [8k+7:8k], k=0 is the rightmost digit
//            pos      - buffer index shown on the leftmost digit
//            wrap     - 1-cycle pulse when pos steps len-1 -> 0
// Config   : define HEX_MARQUEE_BOUNCE_EN to add the bounce input and the
//            scroll direction register.
// Revision : 1.0 - initial release
// ============================================================================
module hex_marquee #(
   parameter int  NUM_DIGITS = 6,
   parameter int  MSG_DEPTH  = 16,
   parameter int  TICK_DIV   = 10_000_000,
   localparam int AW         = $clog2(MSG_DEPTH)
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    run,
   input  logic                    restart,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  logic [7:0]              wr_data,
   input  logic                    len_we,
   input  logic [AW:0]             len_data,
`ifdef HEX_MARQUEE_BOUNCE_EN
   input  logic                    bounce,
`endif
   output logic [NUM_DIGITS*8-1:0] seg_out,
   output logic [AW-1:0]           pos,
   output logic                    wrap
);

   localparam int            CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [AW:0]   DEPTH_L   = (AW+1)'(MSG_DEPTH);

   logic [7:0]              buffer [MSG_DEPTH];
   logic [AW:0]             len;
   logic [CW-1:0]           cnt;
   logic                    tick;
   logic [AW:0]             len_new;
   logic [AW:0]             len_eff;
   logic                    force_zero;
   logic                    pos_last;
   logic [AW-1:0]           pos_nxt;
   logic                    wrap_nxt;
   logic [NUM_DIGITS*8-1:0] seg_nxt;

`ifdef HEX_MARQUEE_BOUNCE_EN
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
   dir_t dir, dir_nxt;
   logic go_up;
   logic pos_prelast;
`endif

   // Length and tick decode. A length load in the same cycle as a tick is
   // honoured by the step, so pos never lands beyond the new length.
   always_comb begin
      tick       = run && (cnt == TICK_LAST);
      len_new    = (len_data > DEPTH_L) ? DEPTH_L : len_data;
      len_eff    = len_we ? len_new : len;
      force_zero = len_we && ((len_new == '0) || (len_new <= {1'b0, pos}));
      pos_last   = ({1'b0, pos} == (len_eff - 1'b1));
   end

   // Scroll step: restart > length force > tick step.
   always_comb begin
      pos_nxt  = pos;
      wrap_nxt = 1'b0;
`ifdef HEX_MARQUEE_BOUNCE_EN
      dir_nxt     = dir;
      go_up       = 1'b0;
      pos_prelast = ({1'b0, pos} + (AW+1)'(2) == len_eff);
`endif
      if (restart || force_zero) begin
         pos_nxt = '0;
`ifdef HEX_MARQUEE_BOUNCE_EN
         dir_nxt = DIR_UP;
`endif
      end else if (tick && (len_eff != '0)) begin
         if (pos_last) begin
            pos_nxt  = '0;
            wrap_nxt = 1'b1;
         end else begin
            pos_nxt = pos + 1'b1;
         end
`ifdef HEX_MARQUEE_BOUNCE_EN
         dir_nxt = DIR_UP;
         if (bounce) begin
            wrap_nxt = 1'b0;
            // Turn around at either end; also recovers if a length change
            // left pos on the last entry while heading up.
            go_up = ((dir == DIR_UP) && !pos_last) || ((dir == DIR_DOWN) && (pos == '0));
            if (len_eff == (AW+1)'(1)) begin
               pos_nxt = '0;
            end else if (go_up) begin
               pos_nxt = pos + 1'b1;
               if (pos_prelast) begin
                  wrap_nxt = 1'b1;
                  dir_nxt  = DIR_DOWN;
               end
            end else begin
               pos_nxt = pos - 1'b1;
               dir_nxt = DIR_DOWN;
               if (pos == AW'(1)) begin
                  wrap_nxt = 1'b1;
                  dir_nxt  = DIR_UP;
               end
            end
         end
`endif
      end
   end

   // Window: digit k shows buffer[pos+NUM_DIGITS-1-k]; past len is blank.
   always_comb begin
      int idx;
      idx     = 0;
      seg_nxt = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         idx = int'(pos) + NUM_DIGITS - 1 - k;
         if (idx < int'(len)) begin
            seg_nxt[8*k +: 8] = buffer[idx[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         len     <= '0;
         pos     <= '0;
         wrap    <= 1'b0;
         seg_out <= '1;
`ifdef HEX_MARQUEE_BOUNCE_EN
         dir     <= DIR_UP;
`endif
      end else begin
         if (restart || tick) begin
            cnt <= '0;
         end else if (run) begin
            cnt <= cnt + 1'b1;
         end
         if (len_we) begin
            len <= len_new;
         end
         pos     <= pos_nxt;
         wrap    <= wrap_nxt;
         seg_out <= seg_nxt;
`ifdef HEX_MARQUEE_BOUNCE_EN
         dir     <= dir_nxt;
`endif
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < MSG_DEPTH; i++) begin
            buffer[i] <= 8'hFF;
         end
      end else if (wr_en && (int'(wr_addr) < MSG_DEPTH)) begin
         buffer[wr_addr] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hex_marquee.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_marquee
// Purpose  : Directed self-checking bench for hex_marquee with TICK_DIV=4,
//            NUM_DIGITS=6, MSG_DEPTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_marquee;

   logic        clock = 1'b0;
   logic        resetn, run, restart, wr_en, len_we;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [4:0]  len_data;
`ifdef HEX_MARQUEE_BOUNCE_EN
   logic        bounce = 1'b0;
`endif
   logic [47:0] seg_out;
   logic [3:0]  pos;
   logic        wrap;

   int vectors     = 0;
   int miscompares = 0;

   localparam logic [47:0] BLANK = {48{1'b1}};

   // Message "GO_BUFFS" as raw active-low patterns.
   logic [7:0]  msg [8] = '{8'hC2, 8'hC0, 8'hF7, 8'h83, 8'hC1, 8'h8E, 8'h8E, 8'h92};
   // Expected HEX5..HEX0 for each pos with len=8.
   logic [47:0] win [8] = '{
      48'hC2C0F783C18E, 48'hC0F783C18E8E, 48'hF783C18E8E92, 48'h83C18E8E92FF,
      48'hC18E8E92FFFF, 48'h8E8E92FFFFFF, 48'h8E92FFFFFFFF, 48'h92FFFFFFFFFF};

   always #5 clock = ~clock;

   hex_marquee #(.NUM_DIGITS(6), .MSG_DEPTH(16), .TICK_DIV(4)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .run      (run),
      .restart  (restart),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .len_we   (len_we),
      .len_data (len_data),
`ifdef HEX_MARQUEE_BOUNCE_EN
      .bounce   (bounce),
`endif
      .seg_out  (seg_out),
      .pos      (pos),
      .wrap     (wrap)
   );

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      resetn = 1'b0; run = 1'b0; restart = 1'b0; wr_en = 1'b0; len_we = 1'b0;
      wr_addr = '0; wr_data = '0; len_data = '0;
      cyc(2);
      check("rst_seg",  seg_out,   BLANK);
      check("rst_pos",  48'(pos),  48'd0);
      check("rst_wrap", 48'(wrap), 48'd0);
      resetn = 1'b1;

      // Empty message: nothing moves, nothing shown.
      run = 1'b1;
      for (int c = 0; c < 100; c++) begin
         cyc(1);
         check("len0_seg",  seg_out,   BLANK);
         check("len0_pos",  48'(pos),  48'd0);
         check("len0_wrap", 48'(wrap), 48'd0);
      end
      run = 1'b0;

      // Load message plus a marker at the last buffer entry.
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = msg[i];
         cyc(1);
      end
      wr_addr = 4'd15; wr_data = 8'hA5;
      cyc(1);
      wr_en = 1'b0; len_we = 1'b1; len_data = 5'd8;
      cyc(1);
      len_we = 1'b0; restart = 1'b1;
      cyc(1);
      restart = 1'b0;
      check("load_pos", 48'(pos), 48'd0);
      check("load_seg", seg_out,  win[0]);

      // Scroll: step every 4 cycles, seg_out lags pos by one cycle.
      run = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         cyc(1);
         check("scroll_pos",  48'(pos),  48'((c / 4) % 8));
         check("scroll_seg",  seg_out,   win[((c - 1) / 4) % 8]);
         check("scroll_wrap", 48'(wrap), 48'(c == 32));
      end

      // Freeze with counter at 2, then resume.
      cyc(2);
      run = 1'b0;
      for (int c = 0; c < 50; c++) begin
         cyc(1);
         check("freeze_pos", 48'(pos), 48'd1);
      end
      run = 1'b1;
      cyc(1);
      check("resume1_pos", 48'(pos), 48'd1);
      cyc(1);
      check("resume2_pos", 48'(pos), 48'd2);

      // Restart in the same cycle as a tick.
      cyc(3);
      restart = 1'b1;
      cyc(1);
      restart = 1'b0;
      check("restart_pos",  48'(pos),  48'd0);
      check("restart_wrap", 48'(wrap), 48'd0);

      // Shrink length below pos.
      cyc(20);
      check("pre_shrink_pos", 48'(pos), 48'd5);
      run = 1'b0; len_we = 1'b1; len_data = 5'd3;
      cyc(1);
      len_we = 1'b0;
      check("shrink_pos",  48'(pos),  48'd0);
      check("shrink_wrap", 48'(wrap), 48'd0);
      cyc(1);
      check("shrink_seg", seg_out, 48'hC2C0F7FFFFFF);

      // Oversized length clamps to 16: wrap at 15 -> 0, no aliasing past 15.
      len_we = 1'b1; len_data = 5'd20; restart = 1'b1;
      cyc(1);
      len_we = 1'b0; restart = 1'b0; run = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         cyc(1);
         if (c == 60) check("clamp_pos15", 48'(pos), 48'd15);
         if (c == 61) check("clamp_seg15", seg_out, 48'hA5FFFFFFFFFF);
         if (c == 63) check("clamp_nowrap", 48'(wrap), 48'd0);
         if (c == 64) begin
            check("clamp_wrap_pos", 48'(pos),  48'd0);
            check("clamp_wrap",     48'(wrap), 48'd1);
         end
      end
      run = 1'b0;

      // Write to a displayed index.
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h11;
      cyc(1);
      wr_en = 1'b0;
      cyc(1);
      check("live_write_seg", seg_out, 48'h11C0F783C18E);

      // Asynchronous reset mid-scroll.
      restart = 1'b1;
      cyc(1);
      restart = 1'b0; run = 1'b1;
      cyc(12);
      check("pre_areset_pos", 48'(pos), 48'd3);
      #2 resetn = 1'b0;
      #1;
      check("areset_seg",  seg_out,   BLANK);
      check("areset_pos",  48'(pos),  48'd0);
      check("areset_wrap", 48'(wrap), 48'd0);
      cyc(1);
      resetn = 1'b1; run = 1'b0; len_we = 1'b1; len_data = 5'd8;
      cyc(1);
      len_we = 1'b0;
      cyc(1);
      check("post_areset_seg", seg_out, BLANK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
